// File: rtl/rom_sum_writer_pkg.sv
// Shared types and constants for the ROM-sum writer sequencer.
package rom_sum_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // Sequencer states: fill the RAM, read it back, flag completion.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // led layout: err_addr in the low ADDR_W bits, status flags directly above
  // it. The flag positions are offsets from bit ADDR_W.
  localparam int LED_ERR_ADDR_LSB = 0;
  localparam int LED_DONE_OFS     = 0;
  localparam int LED_BUSY_OFS     = 1;
  localparam int LED_OVF_OFS      = 2;
  localparam int LED_ERR_OFS      = 3;

endpackage

// File: rtl/rom_sum_writer_if.sv
// Memory-side bus of the sequencer: two async-read ROMs sharing one address,
// and one dual-port RAM (write port A, async read port DPRA).
//
// Bus semantics: there is no valid/ready pair. All reads are combinational
// and complete in the cycle the address is presented. A write happens on
// every rising clk edge that sees ram_we=1, with ram_a and ram_d sampled on
// that same edge. The memories never stall the sequencer.
interface rom_sum_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom1_data;
  logic [DATA_W-1:0] rom2_data;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_dpra;
  logic [DATA_W-1:0] ram_dpo;

  modport master (
    output rom_addr, ram_a, ram_d, ram_we, ram_dpra,
    input  rom1_data, rom2_data, ram_dpo
  );

  modport slave (
    input  rom_addr, ram_a, ram_d, ram_we, ram_dpra,
    output rom1_data, rom2_data, ram_dpo
  );
endinterface

// File: rtl/rom_sum_writer_sum_unit.sv
// Combinational adder: a DATA_W+1-bit sum split into a low word and a carry.
module sum_unit #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  // Zero-extend both operands so the carry is the top bit of the result.
  always_comb begin
    {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
  end

endmodule

// File: rtl/rom_sum_writer.sv
// Sequencer: writes ROM1+ROM2 into a RAM at every address, then reads the RAM
// back and compares each word against a freshly computed sum.
module rom_sum_writer
  import rom_sum_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  rom_sum_if.master         mem,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] led,
  output state_e            dbg_state
);

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [DATA_W-1:0] sum;
  logic              carry;

  // The same adder serves WRITE (data to store) and VERIFY (reference word).
  sum_unit #(.DATA_W(DATA_W)) u_sum (
    .a_i     (mem.rom1_data),
    .b_i     (mem.rom2_data),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // State, counter and sticky flags; reset aborts any run on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next state and memory-bus drive; buses idle at 0 outside their state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    mem.rom_addr = '0;
    mem.ram_a    = '0;
    mem.ram_d    = '0;
    mem.ram_we   = 1'b0;
    mem.ram_dpra = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WRITE;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      ST_WRITE: begin
        mem.rom_addr = cnt_q;
        mem.ram_a    = cnt_q;
        mem.ram_d    = sum;
        mem.ram_we   = 1'b1;
        if (carry) ovf_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_VERIFY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_VERIFY: begin
        mem.rom_addr = cnt_q;
        mem.ram_dpra = cnt_q;
        if (mem.ram_dpo != sum) begin
          err_d = 1'b1;
          // Keep the address of the first mismatch only.
          if (!err_q) err_addr_d = cnt_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs and the packed LED word.
  always_comb begin
    busy      = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
    done      = (state_q == ST_DONE);
    ovf       = ovf_q;
    err       = err_q;
    err_addr  = err_addr_q;
    dbg_state = state_q;
    led       = '0;
    led[LED_ERR_ADDR_LSB +: ADDR_W] = err_addr_q;
    led[ADDR_W + LED_DONE_OFS]      = done;
    led[ADDR_W + LED_BUSY_OFS]      = busy;
    led[ADDR_W + LED_OVF_OFS]       = ovf_q;
    led[ADDR_W + LED_ERR_OFS]       = err_q;
  end

endmodule

// File: tb/tb_rom_sum_writer.sv
// Bench for rom_sum_writer: ROM/RAM models around the DUT, a table of
// deterministic patterns, random runs against a reference model, and
// hand-written sequences for reset, restart and back-to-back operation.
module tb_rom_sum_writer;
  import rom_sum_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = DEPTH;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, ovf, err;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] led;
  state_e        dbg_state;

  always #5 clk = ~clk;

  rom_sum_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  rom_sum_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem       (mem_if),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .err       (err),
    .err_addr  (err_addr),
    .led       (led),
    .dbg_state (dbg_state)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] rom1 [N];
  logic [DW-1:0] rom2 [N];
  logic [DW-1:0] ram  [N];
  logic          corrupt [N];

  assign mem_if.rom1_data = rom1[mem_if.rom_addr];
  assign mem_if.rom2_data = rom2[mem_if.rom_addr];
  // A corrupted location reads back inverted, as if the stored word had been
  // damaged after the WRITE phase.
  assign mem_if.ram_dpo   = corrupt[mem_if.ram_dpra] ? ~ram[mem_if.ram_dpra]
                                                     : ram[mem_if.ram_dpra];

  always @(posedge clk) begin
    if (mem_if.ram_we) ram[mem_if.ram_a] <= mem_if.ram_d;
  end

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic          ovf_trace [0:127];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each RAM word is the 8-bit truncation of ROM1+ROM2; ovf if any
  // plain-integer sum exceeds 255; err/err_addr from the lowest corrupted address.
  task automatic model_run(input logic [N-1:0] cmask, output logic e_ovf,
                           output logic e_err, output logic [AW-1:0] e_addr);
    e_ovf  = 1'b0;
    e_err  = 1'b0;
    e_addr = '0;
    for (int i = 0; i < N; i++) begin
      int s;
      s = int'(rom1[i]) + int'(rom2[i]);
      if (s > 255) e_ovf = 1'b1;
      exp_q.push_back(DW'(s % 256));
    end
    for (int i = 0; i < N; i++) begin
      if (cmask[i] && !e_err) begin
        e_err  = 1'b1;
        e_addr = AW'(i);
      end
    end
  endtask

  // One run from IDLE: start pulse, optional extra start pulse at cycle
  // restart_at, wait for done (bounded), then one more edge back to IDLE.
  task automatic run(input int restart_at, output int done_cyc, output int busy_cnt);
    int cyc;
    start = 1'b1;
    tick();
    cyc      = 1;
    busy_cnt = 0;
    done_cyc = -1;
    while (cyc <= 100) begin
      start = (cyc == restart_at);
      ovf_trace[cyc] = ovf;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    tick();
  endtask

  task automatic check_run(input string nm, input logic [N-1:0] cmask, input int restart_at);
    logic          e_ovf, e_err;
    logic [AW-1:0] e_addr;
    int            dc, bc;
    for (int i = 0; i < N; i++) corrupt[i] = cmask[i];
    model_run(cmask, e_ovf, e_err, e_addr);
    run(restart_at, dc, bc);
    chk({nm, ".done_cycle"}, 32'(dc), 32'd33);
    chk({nm, ".busy_cycles"}, 32'(bc), 32'd32);
    chk({nm, ".idle_after"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({nm, ".ovf"}, 32'(ovf), 32'(e_ovf));
    chk({nm, ".err"}, 32'(err), 32'(e_err));
    chk({nm, ".err_addr"}, 32'(err_addr), 32'(e_addr));
    chk({nm, ".led"}, 32'(led), 32'({e_err, e_ovf, 1'b0, 1'b0, e_addr}));
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] w;
      w = exp_q.pop_front();
      chk($sformatf("%s.ram[%0d]", nm, i), 32'(ram[i]), 32'(w));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".done"}, 32'(done), 32'd0);
    chk({nm, ".ovf"}, 32'(ovf), 32'd0);
    chk({nm, ".err"}, 32'(err), 32'd0);
    chk({nm, ".err_addr"}, 32'(err_addr), 32'd0);
    chk({nm, ".rom_addr"}, 32'(mem_if.rom_addr), 32'd0);
    chk({nm, ".ram_a"}, 32'(mem_if.ram_a), 32'd0);
    chk({nm, ".ram_dpra"}, 32'(mem_if.ram_dpra), 32'd0);
    chk({nm, ".ram_d"}, 32'(mem_if.ram_d), 32'd0);
    chk({nm, ".ram_we"}, 32'(mem_if.ram_we), 32'd0);
    chk({nm, ".led"}, 32'(led), 32'd0);
  endtask

  // ---------------- vector table ----------------
  // ROM1[i] = r1_base + r1_step*i (mod 256), ROM2[i] = r2_const.
  typedef struct {
    logic [DW-1:0] r1_base;
    logic [DW-1:0] r1_step;
    logic [DW-1:0] r2_const;
    logic [N-1:0]  cmask;
    logic          exp_ovf;
    logic          exp_err;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [5];

  task automatic fill_linear(input logic [DW-1:0] base, input logic [DW-1:0] step,
                             input logic [DW-1:0] c);
    for (int i = 0; i < N; i++) begin
      rom1[i] = DW'(int'(base) + int'(step) * i);
      rom2[i] = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int            dc, bc, d1, d2, cyc;
    logic [DW-1:0] old_ram [N];

    vecs[0] = '{8'h00, 8'h01, 8'h10, 16'h0000, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{8'hF0, 8'h01, 8'h10, 16'h0000, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{8'h00, 8'h01, 8'h10, 16'h0208, 1'b0, 1'b1, 4'd3};
    vecs[3] = '{8'h80, 8'h00, 8'h7F, 16'h8000, 1'b0, 1'b1, 4'd15};
    vecs[4] = '{8'h00, 8'h11, 8'hEF, 16'h0001, 1'b1, 1'b1, 4'd0};

    for (int i = 0; i < N; i++) begin
      rom1[i]    = '0;
      rom2[i]    = '0;
      corrupt[i] = 1'b0;
    end

    // Reset state.
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    // Table-driven patterns.
    for (int v = 0; v < 5; v++) begin
      fill_linear(vecs[v].r1_base, vecs[v].r1_step, vecs[v].r2_const);
      check_run($sformatf("vec%0d", v), vecs[v].cmask, 0);
      chk($sformatf("vec%0d.tbl_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      chk($sformatf("vec%0d.tbl_err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d.tbl_err_addr", v), 32'(err_addr), 32'(vecs[v].exp_addr));
    end

    // Overflow at address 5 only; extra start pulse mid-run must be ignored.
    fill_linear(8'h00, 8'h01, 8'h10);
    rom1[5] = 8'hF0;
    rom2[5] = 8'h20;
    check_run("ovf5", '0, 10);
    chk("ovf5.before_edge", 32'(ovf_trace[6]), 32'd0);
    chk("ovf5.after_edge", 32'(ovf_trace[7]), 32'd1);
    chk("ovf5.ram5", 32'(ram[5]), 32'h10);
    repeat (2) tick();
    chk("ovf5.sticky_idle", 32'(ovf), 32'd1);

    // Clean run after a flagged run clears ovf/err.
    fill_linear(8'h01, 8'h02, 8'h03);
    check_run("clean_after_ovf", '0, 0);

    // Random runs checked against the model.
    for (int r = 0; r < 4; r++) begin
      logic [N-1:0] cm;
      for (int i = 0; i < N; i++) begin
        rom1[i] = DW'($urandom_range(0, 255));
        rom2[i] = DW'($urandom_range(0, 255));
      end
      cm = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      check_run($sformatf("rand%0d", r), cm, 0);
    end

    // Reset during WRITE at cnt=7. First a full run with guaranteed overflow.
    for (int i = 0; i < N; i++) begin
      rom1[i] = DW'($urandom_range(128, 255));
      rom2[i] = DW'($urandom_range(128, 255));
    end
    check_run("pre_abort", '0, 0);
    for (int i = 0; i < N; i++) old_ram[i] = ram[i];
    fill_linear(8'h55, 8'h01, 8'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort.rom_addr", 32'(mem_if.rom_addr), 32'd7);
    chk("abort.we_before", 32'(mem_if.ram_we), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("abort");
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort.idle", 32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < N; i++) begin
      if (i <= 7) chk($sformatf("abort.ram[%0d]", i), 32'(ram[i]), 32'(8'h55 + i));
      else        chk($sformatf("abort.ram[%0d]", i), 32'(ram[i]), 32'(old_ram[i]));
    end

    // start held high: back-to-back runs, done 34 cycles apart.
    for (int i = 0; i < N; i++) corrupt[i] = 1'b0;
    start = 1'b1;
    tick();
    cyc = 1;
    d1  = -1;
    d2  = -1;
    while (cyc < 200 && d2 < 0) begin
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin
          d2    = cyc;
          start = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("b2b.first_done", 32'(d1), 32'd33);
    chk("b2b.spacing", 32'(d2 - d1), 32'd34);
    chk("b2b.idle_after", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("b2b.stays_idle", 32'(dbg_state), 32'(ST_IDLE));

    dc = 0;
    bc = 0;
    if (dc != bc) $display("unreachable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_sum_writer.md
# rom_sum_writer

Sequencer that walks every address of two 16×8 asynchronous-read ROMs, adds the paired words, and writes each sum into a 16×8 dual-port distributed RAM. It then reads the RAM back through its second port and checks each word against the sum again. This is the write side of the ROM-adder datapath: the adder output is stored in memory instead of going to the LEDs. The ROMs and RAM are instantiated beside this block, and `led` shows the status.

## Interface
- `ADDR_W`, default 4: address width; depth is 2^ADDR_W.
- `DATA_W`, default 8: data width of the ROMs and the RAM.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level sampled in IDLE; begins a run.
- `rom_addr` output ADDR_W: address to both ROMs (`a` port).
- `rom1_data` input DATA_W: ROM1 `spo`, combinational.
- `rom2_data` input DATA_W: ROM2 `spo`, combinational.
- `ram_a` output ADDR_W: RAM write/port-A address.
- `ram_d` output DATA_W: RAM write data.
- `ram_we` output 1: RAM write enable.
- `ram_dpra` output ADDR_W: RAM read-port address.
- `ram_dpo` input DATA_W: RAM read-port data, combinational.
- `busy` output 1: high in WRITE and VERIFY.
- `done` output 1: one-cycle pulse at end of run.
- `ovf` output 1: sticky; some sum exceeded 2^DATA_W−1 in the current/last run.
- `err` output 1: sticky; a verify mismatch occurred.
- `err_addr` output ADDR_W: address of the first mismatch.
- `led` output DATA_W: {err, ovf, busy, done, err_addr} zero-extended into the low bits; higher bits 0.

## Operation
- States are IDLE, WRITE, VERIFY and DONE. A single counter `cnt` (ADDR_W bits) indexes addresses.
- **IDLE:**
  - `rom_addr`, `ram_a` and `ram_dpra` are 0; `ram_we` is 0.
  - `start`=1 → WRITE, `cnt`←0, `ovf`←0, `err`←0, `err_addr`←0.
- **WRITE:**
  - `rom_addr` = `ram_a` = `cnt`.
  - `sum` = {1'b0,rom1_data} + {1'b0,rom2_data}, DATA_W+1 bits wide.
  - `ram_d` = sum[DATA_W−1:0]; `ram_we` = 1.
  - If sum[DATA_W]=1, `ovf`←1.
  - At `cnt` = max → VERIFY with `cnt`←0; otherwise `cnt`←`cnt`+1.
- **VERIFY:**
  - `rom_addr` = `ram_dpra` = `cnt`; `ram_we` = 0.
  - If `ram_dpo` ≠ sum[DATA_W−1:0]: `err`←1, and `err_addr`←`cnt` only if `err` was 0 (first error only).
  - At `cnt` = max → DONE; otherwise `cnt`+1.
- **DONE:** `done`=1 for this cycle only → IDLE.
- `start` is ignored outside IDLE. `start` held high in IDLE after DONE starts a new run, which clears the flags.
- The address wraps only by state transition; `cnt` never wraps silently inside a state.

## Timing
- Reset values:
  - state IDLE, `cnt` 0;
  - `busy`, `done`, `ovf`, `err` and `ram_we` all 0;
  - `err_addr`, `rom_addr`, `ram_a`, `ram_dpra` and `ram_d` all 0;
  - `led` 0.
- Reset mid-run aborts immediately: `ram_we` drops the same edge and no further writes occur.
- Address and data outputs are combinational from state and `cnt`. ROM and RAM reads are asynchronous, so each read costs 0 wait cycles.
- RAM writes commit on the clk edge that ends each WRITE cycle. The first VERIFY read therefore sees all 16 written words.
- Latency from the `start`-sampling edge:
  - 16 WRITE cycles, then 16 VERIFY cycles;
  - `done` high in cycle 33 (counting the first WRITE cycle as cycle 1);
  - IDLE again in cycle 34.
- `busy` is high exactly 32 cycles per run.
- `ovf` and `err` update on the edge ending the cycle that set them, and stay valid after DONE until the next start or reset.

## Structure
- Shared package `rom_sum_pkg` holds:
  - state encoding typedef (IDLE/WRITE/VERIFY/DONE);
  - `DEPTH` = 2**ADDR_W constant;
  - led field bit-position constants.
- One natural sub-module, `sum_unit`: a combinational DATA_W+1-bit adder that exposes sum and carry, used by both WRITE and VERIFY.
- The ROM and RAM IP cores live in the parent top, not inside this block.

## Test plan
- ROM1[i]=i, ROM2[i]=0x10, start pulse → RAM[i]=0x10+i for all i; `ovf`=0, `err`=0; `done` pulses exactly 33 cycles after start, `busy` high 32 cycles.
- ROM1[5]=0xF0, ROM2[5]=0x20 → RAM[5]=0x10; `ovf`=1 after the WRITE cycle with `cnt`=5 and stays 1 after DONE.
- Bench corrupts the RAM model at addresses 3 and 9 between WRITE and VERIFY → `err`=1, `err_addr`=3 (not 9).
- `rst` asserted during WRITE at `cnt`=7 → `ram_we`=0 from that edge; RAM[8..15] unchanged; all outputs at reset values.
- `start` pulsed again while `busy` → ignored, run length unchanged. A second start after DONE with clean data → `ovf`/`err` cleared to 0.
- `start` held high continuously → back-to-back runs, each 34 cycles IDLE-to-IDLE; `done` pulses 34 cycles apart.
